icache_responder: RTL and testbench
===================================

// Module: icache_responder
// PURPOSE
//  Cache-side responder on the datapath instruction port: answers imemREN/imemaddr with ihit/imemload.
//  Direct-mapped, one word per frame; on a miss it fetches the word from the memory controller
//  (iREN/iaddr, iwait/iload), fills the frame, then hits. Sits between the datapath and the memory controller.
// PARAMETERS
//  SETS      16   number of frames; power of 2, >= 2; IDX_W = $clog2(SETS)
//  PC_INIT   0    unused by this block; tests preload fetches from address 0
// PORTS
//  CLK        in   1   clock, all state updates on posedge
//  nRST       in   1   synchronous active-low reset
//  imemREN    in   1   datapath instruction read request
//  imemaddr   in   32  instruction byte address; bits [1:0] ignored
//  iflush     in   1   invalidate all frames
//  ihit       out  1   imemload valid for imemaddr this cycle
//  imemload   out  32  instruction word
//  iREN       out  1   memory read request
//  iaddr      out  32  memory word address {tag, idx, 2'b00}
//  iwait      in   1   memory busy; iload valid in a cycle where iREN=1 and iwait=0
//  iload      in   32  memory read data
// BEHAVIOUR
//  - Clock is CLK; reset is nRST, synchronous, active-low (sampled on posedge CLK only).
//  - Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2].
//  - Frame = {valid, tag, data}. Reset: all valid=0, state=COMPARE, latched miss address=0.
//  - Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0 until imemREN rises.
//  - FSM COMPARE: hit = imemREN & valid[idx] & (tag match). Hit is combinational, same cycle
//    (0 cycles added): ihit=1, imemload=data[idx]. imemload=0 whenever ihit=0.
//    Miss (imemREN & ~hit & ~iflush): latch word address, go FETCH. No iREN in the detecting cycle.
//  - FSM FETCH: iREN=1, iaddr=latched address; ihit=0. While iwait=1 stay.
//    When iwait=0: write frame[latched idx] = {1, latched tag, iload}, go COMPARE.
//    No forwarding: requester sees ihit on the following cycle (miss latency = mem latency + 2).
//  - Request changes mid-FETCH (imemREN drops or imemaddr moves): fill completes for the latched
//    address anyway; new address evaluated in COMPARE afterwards.
//  - iflush: all valid cleared at next edge; ihit forced 0 in the cycle iflush=1.
//    iflush during FETCH: abort to COMPARE at next edge, no frame written (flush beats fill,
//    even when iwait=0 in the same cycle).
//  - Conflict miss (same idx, different tag) overwrites the frame; no replacement state.
//  - nRST=0 in FETCH: state->COMPARE, iREN=0 from next cycle, no frame written.
//  - imemREN=0 in COMPARE: ihit=0, no state change.
// STRUCTURE
//  - Shared package cpu_types_pkg: icache_frame_t {valid, tag, data}, icachef_t address split
//    struct {tag, idx, bytoff}, ICACHE_SETS constant.
//  - Block-local enum: icache_state_t {COMPARE, FETCH}.
//  - Frame array held in-module as registers (flop array, SETS entries); no sub-module.
// TESTING
//  1 Reset then imemREN=1, addr 0x0000_0000, iwait=1 for 3 cycles then 0, iload=0x2001_0004
//    -> iREN=1, iaddr=0x0 for 4 cycles; next cycle ihit=1, imemload=0x2001_0004.
//  2 Re-read 0x0000_0000 -> ihit=1 same cycle, iREN stays 0.
//  3 Conflict: read 0x0000_0040 (idx 0, new tag), iload=0xDEAD_BEEF -> miss, fill; then 0x0
//    misses again and iaddr=0x0.
//  4 Miss at 0x0000_0008, change imemaddr to 0x0000_000C mid-FETCH -> iaddr holds 0x8 until
//    iwait=0; then 0xC misses, fetched separately.
//  5 iflush=1 with iwait=0 during FETCH -> frame not written, all prior hits now miss.
//  6 nRST=0 in FETCH for one cycle -> iREN=0 next cycle, all frames invalid, ihit=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache frame layout and address split.
// Sized for the default cache geometry used across the datapath.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

endpackage

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache responder.
// Hits answer combinationally; misses fill from the memory controller.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        COMPARE,
        FETCH
    } icache_state_t;

    icache_state_t state, state_n;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [29:0]      miss_q, miss_n;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic             match;
    logic             fill;
    logic [1:0]       unused_bytoff;

    assign req_tag       = imemaddr[31:IDX_W+2];
    assign req_idx       = imemaddr[IDX_W+1:2];
    assign unused_bytoff = imemaddr[1:0];
    assign miss_tag      = miss_q[29:IDX_W];
    assign miss_idx      = miss_q[IDX_W-1:0];

    assign match = valid_q[req_idx]
                 & (tag_q[req_idx] == req_tag);

    always_comb begin
        state_n  = state;
        miss_n   = miss_q;
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        fill     = 1'b0;
        unique case (state)
            COMPARE: begin
                if (imemREN && !iflush) begin
                    if (match) begin
                        ihit     = 1'b1;
                        imemload = data_q[req_idx];
                    end else begin
                        miss_n  = imemaddr[31:2];
                        state_n = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_q, 2'b00};
                // A flush in the same cycle as the reply drops the fill
                if (iflush) begin
                    state_n = COMPARE;
                end else if (!iwait) begin
                    fill    = 1'b1;
                    state_n = COMPARE;
                end
            end
            default: state_n = COMPARE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= COMPARE;
            miss_q <= '0;
        end else begin
            state  <= state_n;
            miss_q <= miss_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST || iflush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[miss_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed-vector bench for icache_responder.
// Inputs change just after posedge; outputs sampled at negedge.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    icache_responder dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic samp();
        @(negedge CLK);
    endtask

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iflush   = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        edge_step();
        edge_step();
        nRST = 1'b1;
        samp();
        check("rst_ihit",  {31'b0, ihit}, 32'h0);
        check("rst_load",  imemload, 32'h0);
        check("rst_iren",  {31'b0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);

        // 1: cold miss at 0x0, 3 wait cycles
        edge_step();
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        iload    = 32'h2001_0004;
        samp();
        check("t1_detect_ihit", {31'b0, ihit}, 32'h0);
        check("t1_detect_iren", {31'b0, iREN}, 32'h0);
        edge_step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) iwait = 1'b0;
            samp();
            check("t1_fetch_iren", {31'b0, iREN}, 32'h1);
            check("t1_fetch_iaddr", iaddr, 32'h0);
            check("t1_fetch_ihit", {31'b0, ihit}, 32'h0);
            edge_step();
        end
        iwait = 1'b1;
        samp();
        check("t1_hit", {31'b0, ihit}, 32'h1);
        check("t1_load", imemload, 32'h2001_0004);

        // 2: re-read hits with no memory request
        edge_step();
        samp();
        check("t2_hit", {31'b0, ihit}, 32'h1);
        check("t2_iren", {31'b0, iREN}, 32'h0);

        // 3: conflict at idx 0
        edge_step();
        imemaddr = 32'h0000_0040;
        iload    = 32'hDEAD_BEEF;
        iwait    = 1'b0;
        samp();
        check("t3_miss", {31'b0, ihit}, 32'h0);
        edge_step();
        samp();
        check("t3_iaddr", iaddr, 32'h40);
        check("t3_iren", {31'b0, iREN}, 32'h1);
        edge_step();
        samp();
        check("t3_hit", {31'b0, ihit}, 32'h1);
        check("t3_load", imemload, 32'hDEAD_BEEF);
        edge_step();
        imemaddr = 32'h0;
        iload    = 32'h2001_0004;
        samp();
        check("t3_evicted", {31'b0, ihit}, 32'h0);
        check("t3_evict_load", imemload, 32'h0);
        edge_step();
        samp();
        check("t3_refetch_iaddr", iaddr, 32'h0);
        edge_step();
        samp();
        check("t3_rehit_load", imemload, 32'h2001_0004);

        // 4: address moves mid-fetch
        edge_step();
        imemaddr = 32'h0000_0008;
        iload    = 32'h1111_1111;
        iwait    = 1'b1;
        samp();
        check("t4_miss8", {31'b0, ihit}, 32'h0);
        edge_step();
        imemaddr = 32'h0000_000C;
        samp();
        check("t4_iaddr_a", iaddr, 32'h8);
        edge_step();
        iwait = 1'b0;
        samp();
        check("t4_iaddr_b", iaddr, 32'h8);
        edge_step();
        iload = 32'h3333_3333;
        samp();
        check("t4_missC_ihit", {31'b0, ihit}, 32'h0);
        check("t4_missC_iren", {31'b0, iREN}, 32'h0);
        edge_step();
        samp();
        check("t4_iaddrC", iaddr, 32'hC);
        edge_step();
        samp();
        check("t4_hitC", imemload, 32'h3333_3333);
        imemaddr = 32'h0000_0008;
        #1;
        check("t4_hit8", imemload, 32'h1111_1111);

        // request dropped: no hit, no state change
        edge_step();
        imemREN = 1'b0;
        samp();
        check("idle_ihit", {31'b0, ihit}, 32'h0);
        edge_step();
        samp();
        check("idle_iren", {31'b0, iREN}, 32'h0);

        // flush masks a would-be hit
        edge_step();
        imemREN = 1'b1;
        iflush  = 1'b1;
        samp();
        check("flush_mask", {31'b0, ihit}, 32'h0);
        check("flush_mask_load", imemload, 32'h0);
        iflush = 1'b0;
        #1;
        check("flush_mask_off", {31'b0, ihit}, 32'h1);

        // 5: flush beats fill during FETCH
        edge_step();
        imemaddr = 32'h0000_0010;
        iload    = 32'h4444_4444;
        iwait    = 1'b0;
        samp();
        check("t5_miss", {31'b0, ihit}, 32'h0);
        edge_step();
        iflush = 1'b1;
        samp();
        check("t5_fetch_iren", {31'b0, iREN}, 32'h1);
        edge_step();
        iflush = 1'b0;
        samp();
        check("t5_nofill", {31'b0, ihit}, 32'h0);
        check("t5_cmp_iren", {31'b0, iREN}, 32'h0);
        imemaddr = 32'h0;
        #1;
        check("t5_flushed0", {31'b0, ihit}, 32'h0);
        imemaddr = 32'h8;
        #1;
        check("t5_flushed8", {31'b0, ihit}, 32'h0);
        imemaddr = 32'hC;
        #1;
        check("t5_flushedC", {31'b0, ihit}, 32'h0);
        imemREN = 1'b0;

        // 6: reset during FETCH
        edge_step();
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0020;
        iload    = 32'h5555_5555;
        iwait    = 1'b0;
        edge_step();
        samp();
        check("t6_fetch_iaddr", iaddr, 32'h20);
        edge_step();
        samp();
        check("t6_filled", imemload, 32'h5555_5555);
        edge_step();
        imemaddr = 32'h0000_0024;
        iwait    = 1'b1;
        edge_step();
        samp();
        check("t6_fetch2", {31'b0, iREN}, 32'h1);
        nRST  = 1'b0;
        iwait = 1'b0;
        edge_step();
        nRST    = 1'b1;
        imemREN = 1'b0;
        samp();
        check("t6_iren", {31'b0, iREN}, 32'h0);
        check("t6_iaddr", iaddr, 32'h0);
        imemREN = 1'b1;
        #1;
        check("t6_no24", {31'b0, ihit}, 32'h0);
        imemaddr = 32'h0000_0020;
        #1;
        check("t6_no20", {31'b0, ihit}, 32'h0);
        imemREN = 1'b0;
        edge_step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
